// File: rtl/mbscore_lsu.sv
// mbscore_lsu: load/store unit for the mbscore pipeline.
// It takes the execute-stage effective address and runs one data-bus
// transaction per memory op. It formats store lanes, extends load data and
// reports a single writeback pulse. A watchdog flags a bus that never acks.
// Optional build macro MBSCORE_LSU_MISALIGN_TRAP_EN traps misaligned
// halfword/word accesses instead of issuing them on the bus.
module mbscore_lsu #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ex_valid,
  input  logic [3:0]                ex_mem_op,
  input  logic [ADDR_WIDTH-1:0]     ex_addr,
  input  logic [DATA_WIDTH-1:0]     ex_store_data,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  output logic                      in_ready,
  output logic                      bus_req,
  output logic                      bus_we,
  output logic [ADDR_WIDTH-1:0]     bus_addr,
  output logic [3:0]                bus_be,
  output logic [DATA_WIDTH-1:0]     bus_wdata,
  input  logic                      bus_ack,
  input  logic [DATA_WIDTH-1:0]     bus_rdata,
  output logic                      wb_valid,
  output logic                      wb_we,
  output logic [REG_ADDR_WIDTH-1:0] wb_rd,
  output logic [DATA_WIDTH-1:0]     wb_data,
  output logic                      bus_err,
  output logic                      misalign_err,
  output logic [ADDR_WIDTH-1:0]     err_addr
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd9;
  localparam logic [3:0] OP_SH  = 4'd10;
  localparam logic [3:0] OP_SW  = 4'd11;

  // The watchdog counts from 0, so the last legal WAIT cycle sees LIMIT-1.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic                      vld_p0;
  logic                      misalign_p0;
  logic                      ack_hit;
  logic                      to_hit;
  logic [7:0]                to_cnt;
  logic [3:0]                op_p1;
  logic [ADDR_WIDTH-1:0]     addr_p1;
  logic [REG_ADDR_WIDTH-1:0] rd_p1;

  function automatic logic op_known(input logic [3:0] op);
    case (op)
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [3:0] op, input logic [1:0] a);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 4'b0001 << a;
      OP_LH, OP_LHU, OP_SH: return a[1] ? 4'b1100 : 4'b0011;
      default:              return 4'b1111;
    endcase
  endfunction

  // Replicate the store operand across every lane it could land in.
  function automatic logic [DATA_WIDTH-1:0] store_fmt(input logic [3:0] op,
                                                      input logic [DATA_WIDTH-1:0] d);
    case (op)
      OP_SB:   return {4{d[7:0]}};
      OP_SH:   return {2{d[15:0]}};
      OP_SW:   return d;
      default: return '0;
    endcase
  endfunction

  // Pick the addressed lane out of the read word and extend it to 32 bits.
  function automatic logic [DATA_WIDTH-1:0] load_ext(input logic [3:0] op,
                                                     input logic [1:0] a,
                                                     input logic [DATA_WIDTH-1:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = a[1] ? rd[31:16] : rd[15:0];
    case (op)
      OP_LB:   return {{24{b[7]}}, b};
      OP_LBU:  return {24'd0, b};
      OP_LH:   return {{16{h[15]}}, h};
      OP_LHU:  return {16'd0, h};
      OP_LW:   return rd;
      default: return '0;
    endcase
  endfunction

`ifdef MBSCORE_LSU_MISALIGN_TRAP_EN
  function automatic logic misaligned(input logic [3:0] op, input logic [1:0] a);
    case (op)
      OP_LH, OP_LHU, OP_SH: return a[0];
      OP_LW, OP_SW:         return |a;
      default:              return 1'b0;
    endcase
  endfunction

  assign misalign_p0 = misaligned(ex_mem_op, ex_addr[1:0]);
`else
  assign misalign_p0 = 1'b0;
`endif

  assign in_ready = (state == ST_IDLE);

  // Next-state decode plus the one-cycle events that drive the output registers.
  always_comb begin
    state_nxt = state;
    vld_p0    = 1'b0;
    ack_hit   = 1'b0;
    to_hit    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ex_valid && op_known(ex_mem_op)) begin
          vld_p0    = 1'b1;
          state_nxt = misalign_p0 ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        // An ack on the limit cycle still completes the access.
        if (bus_ack) begin
          ack_hit   = 1'b1;
          state_nxt = ST_DONE;
        end else if (to_cnt == TO_LAST) begin
          to_hit    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // ---- stage p0 -> p1: capture the accepted op for use during WAIT ----
  // Operand latch; only read while an op is in flight, so it needs no reset.
  always_ff @(posedge clk) begin
    if (vld_p0) begin
      op_p1   <= ex_mem_op;
      addr_p1 <= ex_addr;
      rd_p1   <= ex_rd;
    end
  end

  // ---- stage p1 -> p2: bus request, watchdog, writeback and error reporting ----
  // Registered bus/writeback/error outputs and the timeout counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= '0;
      bus_be       <= '0;
      bus_wdata    <= '0;
      wb_valid     <= 1'b0;
      wb_we        <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      bus_err      <= 1'b0;
      misalign_err <= 1'b0;
      err_addr     <= '0;
      to_cnt       <= '0;
    end else begin
      wb_valid     <= 1'b0;
      bus_err      <= 1'b0;
      misalign_err <= 1'b0;
      if (vld_p0) begin
        to_cnt <= '0;
        if (misalign_p0) begin
          misalign_err <= 1'b1;
          err_addr     <= ex_addr;
        end else begin
          bus_req   <= 1'b1;
          bus_we    <= ex_mem_op[3];
          bus_addr  <= {ex_addr[ADDR_WIDTH-1:2], 2'b00};
          bus_be    <= lane_be(ex_mem_op, ex_addr[1:0]);
          bus_wdata <= store_fmt(ex_mem_op, ex_store_data);
        end
      end
      if (ack_hit) begin
        bus_req  <= 1'b0;
        wb_valid <= 1'b1;
        wb_we    <= ~op_p1[3];
        wb_rd    <= rd_p1;
        wb_data  <= op_p1[3] ? '0 : load_ext(op_p1, addr_p1[1:0], bus_rdata);
      end else if (to_hit) begin
        bus_req  <= 1'b0;
        bus_err  <= 1'b1;
        err_addr <= addr_p1;
      end else if (state == ST_WAIT) begin
        to_cnt <= to_cnt + 8'd1;
      end
    end
  end

endmodule
